// File: rtl/pierogi_alu_pkg.sv
// Shared ALU definitions: divider FSM states, default datapath width, sign helper.
// abs_w works on a zero-extended 64-bit view so one function serves any WIDTH <= 64.
package pierogi_alu_pkg;

   localparam int DIV_W = 32;

   typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} div_state_t;

   // Magnitude of a w-bit value held in the low bits of v; caller truncates the result to w bits.
   function automatic logic [63:0] abs_w(input logic [63:0] v, input int w, input logic sgn);
      logic neg;
      neg = sgn && ((v & (64'd1 << (w - 1))) != 64'd0);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract the divisor.
// Purely combinational; the extra top bit of trial is the borrow.
module div_step
   import pierogi_alu_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             q_bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit_out
);

   logic [WIDTH+1:0] trial;

   // rem_in < divisor always, so the shifted value needs WIDTH+1 bits for divisors above 2^(WIDTH-1).
   assign trial     = {1'b0, rem_in, q_bit_in} - {2'b00, divisor};
   assign q_bit_out = ~trial[WIDTH+1];
   assign rem_out   = q_bit_out ? WIDTH'(trial) : WIDTH'({rem_in, q_bit_in});

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider (signed/unsigned); done arrives WIDTH+2 cycles after accept, 2 on divide-by-zero.
// start is honoured only in IDLE; busy covers PREP and CALC, done is the FIX cycle.
module seq_divider
   import pierogi_alu_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   div_state_t       state;
   logic [WIDTH-1:0] a_raw, b_raw;
   logic [WIDTH-1:0] q_reg, d_reg, rem;
   logic [WIDTH-1:0] q_hold, r_hold;
   logic [WIDTH-1:0] q_fix, r_fix;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic             sgn, q_neg, r_neg, dz, dz_hold;
   logic [CW-1:0]    count;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in    (rem),
      .q_bit_in  (q_reg[WIDTH-1]),
      .divisor   (d_reg),
      .rem_out   (step_rem),
      .q_bit_out (step_q)
   );

   always_comb begin
      q_fix = q_neg ? -q_reg : q_reg;
      r_fix = r_neg ? -rem : rem;
      if (dz) begin
         q_fix = '1;
         r_fix = a_raw;
      end
   end

   // Results are presented live during FIX so they are valid in the done cycle itself.
   assign done      = (state == FIX);
   assign busy      = (state == PREP) || (state == CALC);
   assign quotient  = done ? q_fix : q_hold;
   assign remainder = done ? r_fix : r_hold;
   assign div_zero  = done ? dz : dz_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_raw   <= '0;
         b_raw   <= '0;
         q_reg   <= '0;
         d_reg   <= '0;
         rem     <= '0;
         q_hold  <= '0;
         r_hold  <= '0;
         sgn     <= 1'b0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         dz      <= 1'b0;
         dz_hold <= 1'b0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_raw <= dividend;
                  b_raw <= divisor;
                  sgn   <= is_signed;
                  state <= PREP;
               end
            end
            PREP: begin
               q_reg <= WIDTH'(abs_w(64'(a_raw), WIDTH, sgn));
               d_reg <= WIDTH'(abs_w(64'(b_raw), WIDTH, sgn));
               q_neg <= sgn & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
               r_neg <= sgn & a_raw[WIDTH-1];
               rem   <= '0;
               count <= CW'(WIDTH - 1);
               dz    <= (b_raw == '0);
               state <= (b_raw == '0) ? FIX : CALC;
            end
            CALC: begin
               rem   <= step_rem;
               q_reg <= {q_reg[WIDTH-2:0], step_q};
               count <= count - CW'(1);
               if (count == '0) state <= FIX;
            end
            FIX: begin
               q_hold  <= q_fix;
               r_hold  <= r_fix;
               dz_hold <= dz;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: results, latency, handshake and mid-operation reset.
module tb_seq_divider;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          is_signed = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          busy, done, div_zero;
   logic [W-1:0]  quotient, remainder;

   int n_cmp = 0;
   int n_bad = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called in the low phase; start is raised immediately. inj_a/inj_b are cycles at which
   // a junk start is pulsed while the operation is in flight (-1 = none).
   task automatic run_div(input string tag, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q_exp, input logic [W-1:0] r_exp, input logic dz_exp,
                          input int lat_exp, input int inj_a, input int inj_b);
      int   cyc;
      logic got;
      is_signed = sg;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      cyc       = 0;
      got       = 1'b0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         start = (cyc == inj_a) || (cyc == inj_b);
         dividend  = start ? 32'h5 : ~a;
         divisor   = start ? 32'h0 : ~b;
         is_signed = ~sg;
         if (cyc == 1) begin
            check_eq({tag, "/busy1"}, busy, 1'b1);
            check_eq({tag, "/done1"}, done, 1'b0);
         end
         if (done) got = 1'b1;
      end
      check_eq({tag, "/latency"}, cyc, lat_exp);
      check_eq({tag, "/busy_at_done"}, busy, 1'b0);
      check_eq({tag, "/q"}, quotient, q_exp);
      check_eq({tag, "/r"}, remainder, r_exp);
      check_eq({tag, "/dz"}, div_zero, dz_exp);
      start = 1'b0;
      @(negedge clk);
      check_eq({tag, "/done_pulse"}, done, 1'b0);
      check_eq({tag, "/idle_after"}, busy, 1'b0);
      check_eq({tag, "/q_hold"}, quotient, q_exp);
      check_eq({tag, "/r_hold"}, remainder, r_exp);
   endtask

   initial begin
      int seen;
      repeat (3) @(negedge clk);
      check_eq("rst/busy", busy, 1'b0);
      check_eq("rst/done", done, 1'b0);
      check_eq("rst/q", quotient, 32'h0);
      check_eq("rst/r", remainder, 32'h0);
      check_eq("rst/dz", div_zero, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      run_div("u100_7",   1'b0, 32'd100,      32'd7,        32'h0000000E, 32'h00000002, 1'b0, 34, -1, -1);
      run_div("s-7_2",    1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, -1, -1);
      run_div("s7_-2",    1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 34, -1, -1);
      run_div("s-7_-2",   1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 34, -1, -1);
      run_div("s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 34, -1, -1);
      run_div("u_max_1",  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34, -1, -1);
      run_div("u_bigdiv", 1'b0, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 32'h7FFFFFFE, 1'b0, 34, -1, -1);
      run_div("u_dz",     1'b0, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h00001234, 1'b1, 2,  -1, -1);
      run_div("s_dz",     1'b1, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 2,  -1, -1);

      // Junk starts while busy (cycle 10) and in the done/FIX cycle (34) must be ignored.
      run_div("hs",       1'b0, 32'd1000,     32'd10,       32'h00000064, 32'h00000000, 1'b0, 34, 10, 34);
      // Issued on the cycle right after the previous done.
      run_div("b2b",      1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0, 34, -1, -1);

      is_signed = 1'b0;
      dividend  = 32'h0000FFFF;
      divisor   = 32'h00000003;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      check_eq("mid/busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("mid/busy", busy, 1'b0);
      check_eq("mid/done", done, 1'b0);
      check_eq("mid/q", quotient, 32'h0);
      check_eq("mid/r", remainder, 32'h0);
      check_eq("mid/dz", div_zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check_eq("mid/no_done", seen, 0);

      run_div("after_rst", 1'b0, 32'hDEADBEEF, 32'h00000010, 32'h0DEADBEE, 32'h0000000F, 1'b0, 34, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
